// File: rtl/aemb2_wbcopy.sv
// Wishbone classic-cycle block-copy engine: reads one word, writes it back out, len times.
// Optional pattern-fill mode (writes only) is compiled in with `define AEMB2_WBCOPY_FILL_EN.
module aemb2_wbcopy #(
    parameter int AW = 14,
    parameter int LW = 12
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          start_i,
    input  logic [AW-3:0] src_i,
    input  logic [AW-3:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic          abort_i,
    input  logic          fill_i,
    input  logic [31:0]   pat_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-3:0] dwb_adr_o,
    output logic [31:0]   dwb_dat_o,
    output logic [3:0]    dwb_sel_o,
    output logic          dwb_wre_o,
    output logic          dwb_stb_o,
    output logic          dwb_cyc_o,
    output logic          dwb_tag_o,
    input  logic [31:0]   dwb_dat_i,
    input  logic          dwb_ack_i,
    output logic [2:0]    dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RGAP = 3'd2,
        S_WR   = 3'd3,
        S_WGAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [AW-3:0] A_ONE = {{(AW-3){1'b0}}, 1'b1};
    localparam logic [LW-1:0] L_ONE = {{(LW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next;
    logic [AW-3:0] r_src;
    logic [AW-3:0] r_dst;
    logic [LW-1:0] r_cnt;
    logic [31:0]   r_hold;
    logic          r_abort;
    logic          r_fill;
    logic          w_fill_start;
    logic          w_abort;
    logic          w_go;

`ifdef AEMB2_WBCOPY_FILL_EN
    assign w_fill_start = fill_i;
`else
    logic w_unused;
    assign w_fill_start = 1'b0;
    assign w_unused     = ^{fill_i, pat_i};
`endif

    assign w_go        = start_i && (len_i != '0);
    assign w_abort     = r_abort | abort_i;
    assign dbg_state_o = r_state;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Bus handshake: a cycle opens with stb=cyc=1 and holds every bus output
    // steady until the edge that samples ack=1; stb then drops for at least one
    // cycle. ack is only looked at in RD/WR, so an ack while stb=0 does nothing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0)       w_next = S_DONE;
                    else if (w_fill_start) w_next = S_WR;
                    else                   w_next = S_RD;
                end
            end
            S_RD:   if (dwb_ack_i) w_next = S_RGAP;
            S_RGAP: w_next = S_WR;
            S_WR: begin
                if (dwb_ack_i) begin
                    if (r_cnt == L_ONE || w_abort) w_next = S_DONE;
                    else                           w_next = S_WGAP;
                end
            end
            S_WGAP: begin
                if (w_abort)     w_next = S_DONE;
                else if (r_fill) w_next = S_WR;
                else             w_next = S_RD;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_abort <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            if (abort_i) r_abort <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    // A same-cycle abort is dropped: the pending flag only lives while busy.
                    r_abort <= 1'b0;
                    if (w_go) begin
                        r_src  <= src_i;
                        r_dst  <= dst_i;
                        r_cnt  <= len_i;
                        r_fill <= w_fill_start;
                        if (w_fill_start) r_hold <= pat_i;
                    end
                end
                S_RD: if (dwb_ack_i) r_hold <= dwb_dat_i;
                S_WR: begin
                    if (dwb_ack_i) begin
                        r_src <= r_src + A_ONE;
                        r_dst <= r_dst + A_ONE;
                        r_cnt <= r_cnt - L_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        dwb_adr_o = '0;
        dwb_dat_o = '0;
        dwb_sel_o = 4'h0;
        dwb_wre_o = 1'b0;
        dwb_stb_o = 1'b0;
        case (r_state)
            S_RD: begin
                busy_o    = 1'b1;
                dwb_stb_o = 1'b1;
                dwb_sel_o = 4'hF;
                dwb_adr_o = r_src;
            end
            S_WR: begin
                busy_o    = 1'b1;
                dwb_stb_o = 1'b1;
                dwb_sel_o = 4'hF;
                dwb_wre_o = 1'b1;
                dwb_adr_o = r_dst;
                dwb_dat_o = r_hold;
            end
            S_RGAP, S_WGAP: busy_o = 1'b1;
            S_DONE:         done_o = 1'b1;
            default: ;
        endcase
    end

    assign dwb_cyc_o = dwb_stb_o;
    assign dwb_tag_o = 1'b0;

endmodule
